// File: rtl/regfile_port_ctrl_pkg.sv
// Shared types for the register-file sweep controller:
// FSM state encoding and operation mode constants.
package regfile_port_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Register-file ports plus LOAD input and DUMP output streams
// between the sweep controller (master) and its environment (slave).
interface regfile_port_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);

    logic              rf_regwr;
    logic [IDX_W-1:0]  rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic [IDX_W-1:0]  rf_ra;
    logic [DATA_W-1:0] rf_outa;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output rf_regwr, rf_rd, rf_data, rf_ra,
        input  rf_outa,
        input  s_valid, s_data,
        output s_ready,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  rf_regwr, rf_rd, rf_data, rf_ra,
        output rf_outa,
        output s_valid, s_data,
        input  s_ready,
        input  m_valid, m_data, m_last,
        output m_ready
    );

endinterface

// File: rtl/regfile_port_ctrl.sv
// Sweeps every architectural register: DUMP streams them out,
// LOAD writes them from an input stream, one word per cycle.
module regfile_port_ctrl
    import regfile_port_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    output logic                 busy,
    output logic                 done,
    regfile_port_ctrl_if.master  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic in_dump;
    logic in_load;
    logic at_last;
    logic m_xfer;
    logic s_xfer;

    assign in_dump = (state_q == ST_DUMP);
    assign in_load = (state_q == ST_LOAD);
    assign at_last = (idx_q == LAST_IDX);

    // Reset gates the handshakes so nothing commits in the reset cycle
    assign bus.m_valid  = in_dump && !reset;
    assign bus.s_ready  = in_load && !reset;
    assign bus.rf_regwr = bus.s_ready && bus.s_valid;

    assign m_xfer = bus.m_valid && bus.m_ready;
    assign s_xfer = bus.rf_regwr;

    assign bus.rf_ra   = idx_q;
    assign bus.m_data  = bus.rf_outa;
    assign bus.m_last  = in_dump && at_last;
    assign bus.rf_rd   = idx_q;
    assign bus.rf_data = bus.s_data;

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (mode == MODE_LOAD) ? ST_LOAD : ST_DUMP;
                    idx_d   = '0;
                end
            end
            ST_DUMP: begin
                if (m_xfer) begin
                    if (at_last) state_d = ST_DONE;
                    else         idx_d   = idx_q + 1'b1;
                end
            end
            ST_LOAD: begin
                if (s_xfer) begin
                    if (at_last) state_d = ST_DONE;
                    else         idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench: sweep controller driving a behavioural
// register file, with stream stimulus and hand-computed checks.
module tb_regfile_port_ctrl;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam int IW = 5;

    logic clk;
    logic reset;
    logic start;
    logic mode;
    logic busy;
    logic done;

    int total;
    int bad;

    logic [DW-1:0] rf [NR];

    regfile_port_ctrl_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    regfile_port_ctrl #(
        .NUM_REGS(NR),
        .DATA_W  (DW),
        .IDX_W   (IW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .mode (mode),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bus.rf_regwr) rf[bus.rf_rd] <= bus.rf_data;
    end

    assign bus.rf_outa = rf[bus.rf_ra];

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy_done got=%b%b want=00", busy, done);
        end
        total++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs got=%b%b want=00",
                     bus.m_valid, bus.s_ready);
        end
        total++;
        if (bus.rf_ra !== 5'd0 || bus.rf_regwr !== 1'b0) begin
            bad++;
            $display("FAIL reset_idx got ra=%0d we=%b want 0/0",
                     bus.rf_ra, bus.rf_regwr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_full();
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        total++;
        if (bus.s_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL load_latency got rdy=%b busy=%b want 1/1",
                     bus.s_ready, busy);
        end
        for (int i = 0; i < NR; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'(i + 2);
            #1;
            total++;
            if (bus.rf_regwr !== 1'b1 || bus.rf_rd !== IW'(i)) begin
                bad++;
                $display("FAIL load_write i=%0d got we=%b rd=%0d want 1/%0d",
                         i, bus.rf_regwr, bus.rf_rd, i);
            end
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || bus.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_done got done=%b rdy=%b want 1/0",
                     done, bus.s_ready);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL load_idle got done=%b busy=%b want 0/0",
                     done, busy);
        end
        total++;
        if (rf[5] !== 32'd7) begin
            bad++;
            $display("FAIL load_r5 got=%0d want=7", rf[5]);
        end
        for (int i = 0; i < NR; i++) begin
            total++;
            if (rf[i] !== DW'(i + 2)) begin
                bad++;
                $display("FAIL load_rf r%0d got=%0d want=%0d", i, rf[i], i + 2);
            end
        end
    endtask

    task automatic test_dump_full();
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        start       = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            #1;
            total++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== DW'(i + 2)) begin
                bad++;
                $display("FAIL dump_beat i=%0d got v=%b d=%0d want 1/%0d",
                         i, bus.m_valid, bus.m_data, i + 2);
            end
            total++;
            if (bus.m_last !== (i == NR - 1)) begin
                bad++;
                $display("FAIL dump_last i=%0d got=%b", i, bus.m_last);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (done !== 1'b1 || bus.m_valid !== 1'b0) begin
            bad++;
            $display("FAIL dump_done got done=%b v=%b want 1/0",
                     done, bus.m_valid);
        end
        @(negedge clk);
        bus.m_ready = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL dump_idle got done=%b busy=%b want 0/0",
                     done, busy);
        end
    endtask

    // Shared by the backpressure and start-ignored scenarios
    task automatic run_dump(input bit bp, input bit poke, input string nm);
        int k;
        int dones;
        int c;
        k     = 0;
        dones = 0;
        c     = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (c < 200 && !(dones > 0 && !busy)) begin
            bus.m_ready = bp ? (c % 3 == 0) : 1'b1;
            start = poke && (k == 10);
            mode  = 1'b1;
            #1;
            if (done) dones++;
            if (bus.m_valid) begin
                total++;
                if (k >= NR || bus.m_data !== DW'(k + 2)) begin
                    bad++;
                    $display("FAIL %s_data k=%0d got=%0d want=%0d",
                             nm, k, bus.m_data, k + 2);
                end
                total++;
                if (bus.m_last !== (k == NR - 1)) begin
                    bad++;
                    $display("FAIL %s_last k=%0d got=%b", nm, k, bus.m_last);
                end
                if (bus.m_ready) k++;
            end
            @(negedge clk);
            c++;
        end
        start       = 1'b0;
        bus.m_ready = 1'b0;
        total++;
        if (k != NR || dones != 1 || c >= 200) begin
            bad++;
            $display("FAIL %s_count got beats=%0d dones=%0d cyc=%0d want 32/1",
                     nm, k, dones, c);
        end
    endtask

    task automatic test_dump_backpressure();
        run_dump(1'b1, 1'b0, "dump_bp");
    endtask

    task automatic test_start_ignored();
        run_dump(1'b0, 1'b1, "start_ign");
    endtask

    task automatic test_load_gaps();
        int k;
        int c;
        k = 0;
        c = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < NR && c < 200) begin
            bus.s_valid = (c % 4 == 0) || (c % 4 == 3);
            bus.s_data  = DW'(100 + k);
            #1;
            total++;
            if (bus.rf_regwr !== bus.s_valid || bus.rf_rd !== IW'(k)) begin
                bad++;
                $display("FAIL gaps_wr c=%0d got we=%b rd=%0d want %b/%0d",
                         c, bus.rf_regwr, bus.rf_rd, bus.s_valid, k);
            end
            if (bus.s_valid) k++;
            @(negedge clk);
            c++;
        end
        bus.s_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || c >= 200) begin
            bad++;
            $display("FAIL gaps_done got=%b cyc=%0d want 1", done, c);
        end
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            total++;
            if (rf[i] !== DW'(100 + i)) begin
                bad++;
                $display("FAIL gaps_rf r%0d got=%0d want=%0d",
                         i, rf[i], 100 + i);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'(500 + i);
            @(negedge clk);
        end
        bus.s_data = DW'(999);
        reset      = 1'b1;
        #1;
        total++;
        if (bus.rf_regwr !== 1'b0 || bus.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_gate got we=%b rdy=%b want 0/0",
                     bus.rf_regwr, bus.s_ready);
        end
        @(negedge clk);
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.rf_ra !== 5'd0) begin
            bad++;
            $display("FAIL rst_idle got busy=%b done=%b ra=%0d want 0/0/0",
                     busy, done, bus.rf_ra);
        end
        for (int i = 0; i < NR; i++) begin
            total++;
            if (rf[i] !== DW'(i < 10 ? 500 + i : 100 + i)) begin
                bad++;
                $display("FAIL rst_rf r%0d got=%0d", i, rf[i]);
            end
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        start       = 1'b0;
        mode        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_load_full();
        test_dump_full();
        test_dump_backpressure();
        test_start_ignored();
        test_load_gaps();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
